// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the remote command UART link
package uart_pkg;
   localparam int BAUD_DIV_DEF = 434;
   localparam logic [7:0] POS_ACK = 8'hA5;
   typedef enum logic {HIGH, LOW} asm_state_t;
endpackage

// File: rtl/uart_trx.sv
// uart_trx: generic 8N1 receiver and transmitter sharing one baud divisor
module uart_trx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic       TX,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   input  logic       clr_rx_rdy,
   input  logic       trmt,
   input  logic [7:0] resp,
   output logic       tx_done
);
   localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);
   localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);

   logic        rx_ff1, rx_ff2, rx_ff3, rx_busy, tx_busy;
   logic [11:0] rx_baud, tx_baud;
   logic [3:0]  rx_bit, tx_bit;
   logic [7:0]  rx_shift;
   logic [8:0]  tx_shift;

   assign rx_data = rx_shift;
   assign TX      = tx_shift[0];

   // Preset to 1 so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {rx_ff3, rx_ff2, rx_ff1} <= 3'b111;
      else        {rx_ff3, rx_ff2, rx_ff1} <= {rx_ff2, rx_ff1, RX};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rx_busy  <= 1'b0;
         rx_baud  <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_rdy   <= 1'b0;
      end else begin
         if (clr_rx_rdy) rx_rdy <= 1'b0;
         if (!rx_busy) begin
            if (!rx_ff2 && rx_ff3) begin
               rx_busy <= 1'b1;
               rx_baud <= HALF;
               rx_bit  <= '0;
               rx_rdy  <= 1'b0;
            end
         end else if (rx_baud != '0) rx_baud <= rx_baud - 12'd1;
         else begin
            rx_baud <= FULL;
            rx_bit  <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) rx_busy <= !rx_ff2;
            else if (rx_bit == 4'd9) begin
               rx_busy <= 1'b0;
               rx_rdy  <= rx_ff2;
            end else rx_shift <= {rx_ff2, rx_shift[7:1]};
         end
      end

   // Idle shift register holds all ones, so TX idles high straight from a flop
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tx_shift <= '1;
         tx_busy  <= 1'b0;
         tx_baud  <= '0;
         tx_bit   <= '0;
         tx_done  <= 1'b0;
      end else if (!tx_busy) begin
         if (trmt) begin
            tx_shift <= {resp, 1'b0};
            tx_busy  <= 1'b1;
            tx_baud  <= FULL;
            tx_bit   <= '0;
            tx_done  <= 1'b0;
         end
      end else if (tx_baud != '0) tx_baud <= tx_baud - 12'd1;
      else if (tx_bit == 4'd9) begin
         tx_busy <= 1'b0;
         tx_done <= 1'b1;
      end else begin
         tx_shift <= {1'b1, tx_shift[8:1]};
         tx_bit   <= tx_bit + 4'd1;
         tx_baud  <= FULL;
      end
endmodule

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: assembles two received bytes into a 16-bit command and returns a response byte
module uart_cmd_wrapper
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        trmt,
   output logic        tx_done
);
   asm_state_t  state, nxt_state;
   logic [7:0]  rx_data, high_byte, nxt_high;
   logic [15:0] nxt_cmd;
   logic        rx_rdy, nxt_rdy;

   uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .rx_data    (rx_data),
      .rx_rdy     (rx_rdy),
      .clr_rx_rdy (rx_rdy),
      .trmt       (trmt),
      .resp       (resp),
      .tx_done    (tx_done)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= HIGH;
         high_byte <= '0;
         cmd       <= '0;
         cmd_rdy   <= 1'b0;
      end else begin
         state     <= nxt_state;
         high_byte <= nxt_high;
         cmd       <= nxt_cmd;
         cmd_rdy   <= nxt_rdy;
      end

   // High byte is staged separately so cmd never changes while cmd_rdy is high
   always_comb begin
      nxt_state = state;
      nxt_high  = high_byte;
      nxt_cmd   = cmd;
      nxt_rdy   = cmd_rdy & ~clr_cmd_rdy;
      if (rx_rdy) begin
         nxt_state = (state == HIGH) ? LOW : HIGH;
         nxt_high  = (state == HIGH) ? rx_data : high_byte;
         nxt_cmd   = (state == HIGH) ? cmd : {high_byte, rx_data};
         nxt_rdy   = (state == LOW);
      end
   end
endmodule
